idelay_sweep_controller: RTL and testbench

Sequencer that sweeps an IDELAY tap value across its range and, for each tap, clears an external error counter, waits for the delay line to settle, runs the error counter for a fixed dwell window and hands the captured (tap, error count) pair to a downstream consumer through a valid/ready handshake. It sits between the UART command path and the IDELAY/ISERDES/error-counter datapath of the histogram design. It replaces free-running delay stepping with a deterministic, back-pressurable measurement schedule.

---
 rtl/idelay_sweep_controller.sv | 139 +++++++++++++
 tb/tb_idelay_sweep_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idelay_sweep_controller.sv
// idelay_sweep_controller: per-tap load/settle/dwell/capture/report
// sequencer for the IDELAY histogram datapath.
module idelay_sweep_controller #(
   parameter int TAPS          = 32,
   parameter int SETTLE_CYCLES = 16,
   parameter int DWELL_CYCLES  = 1024,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [4:0]           delay,
   output logic                 delay_ld,
   output logic                 err_clr,
   output logic                 err_en,
   input  logic [CNT_WIDTH-1:0] err_cnt,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [4:0]           res_delay,
   output logic [CNT_WIDTH-1:0] res_count
);

   localparam int SW =
      (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [SW-1:0] SETTLE_LAST =
      SW'(SETTLE_CYCLES - 1);

   localparam logic [15:0] DWELL_LAST =
      16'(DWELL_CYCLES - 1);

   localparam logic [4:0] TAP_LAST = 5'(TAPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_MEASURE,
      S_CAPTURE,
      S_REPORT,
      S_NEXT
   } state_t;

   state_t        state;
   logic [4:0]    tap;
   logic [SW-1:0] settle_cnt;
   logic [15:0]   dwell_cnt;
   logic          last_tap;

   assign last_tap = (tap == TAP_LAST);

   // Sweep FSM; every output is a register set for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tap        <= '0;
         settle_cnt <= '0;
         dwell_cnt  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         delay      <= '0;
         delay_ld   <= 1'b0;
         err_clr    <= 1'b0;
         err_en     <= 1'b0;
         res_valid  <= 1'b0;
         res_delay  <= '0;
         res_count  <= '0;
      end else begin
         delay_ld <= 1'b0;
         err_clr  <= 1'b0;
         done     <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_LOAD;
                  tap      <= '0;
                  delay    <= '0;
                  delay_ld <= 1'b1;
                  err_clr  <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_LOAD: begin
               state      <= S_SETTLE;
               settle_cnt <= SETTLE_LAST;
            end
            S_SETTLE: begin
               if (settle_cnt == '0) begin
                  state     <= S_MEASURE;
                  err_en    <= 1'b1;
                  dwell_cnt <= DWELL_LAST;
               end else begin
                  settle_cnt <= settle_cnt - SW'(1);
               end
            end
            S_MEASURE: begin
               if (dwell_cnt == 16'd0) begin
                  state  <= S_CAPTURE;
                  err_en <= 1'b0;
               end else begin
                  dwell_cnt <= dwell_cnt - 16'd1;
               end
            end
            S_CAPTURE: begin
               // err_cnt lags err_en by one cycle, so it is final here.
               state     <= S_REPORT;
               res_count <= err_cnt;
               res_delay <= tap;
               res_valid <= 1'b1;
            end
            S_REPORT: begin
               if (res_ready) begin
                  state     <= S_NEXT;
                  res_valid <= 1'b0;
                  done      <= last_tap;
               end
            end
            S_NEXT: begin
               if (last_tap) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state    <= S_LOAD;
                  tap      <= tap + 5'd1;
                  delay    <= tap + 5'd1;
                  delay_ld <= 1'b1;
                  err_clr  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_idelay_sweep_controller.sv
// tb_idelay_sweep_controller: directed sweeps on a short and a
// full-range configuration with a counting error-counter model.
module tb_idelay_sweep_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_a, start_b;
   logic ready_a, ready_b, force_ff;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Instance A: TAPS=4, SETTLE=2, DWELL=8
   logic        busy_a, done_a, ld_a, clr_a, en_a;
   logic        valid_a;
   logic [4:0]  delay_a, rdel_a;
   logic [15:0] cnt_a, rcnt_a, ecnt_a;

   // Instance B: TAPS=32, SETTLE=1, DWELL=1
   logic        busy_b, done_b, ld_b, clr_b, en_b;
   logic        valid_b;
   logic [4:0]  delay_b, rdel_b;
   logic [15:0] cnt_b, rcnt_b, ecnt_b;

   idelay_sweep_controller #(
      .TAPS(4), .SETTLE_CYCLES(2),
      .DWELL_CYCLES(8), .CNT_WIDTH(16)
   ) u_a (
      .clk(clk), .rst(rst), .start(start_a),
      .busy(busy_a), .done(done_a),
      .delay(delay_a), .delay_ld(ld_a),
      .err_clr(clr_a), .err_en(en_a),
      .err_cnt(cnt_a), .res_valid(valid_a),
      .res_ready(ready_a), .res_delay(rdel_a),
      .res_count(rcnt_a)
   );

   idelay_sweep_controller #(
      .TAPS(32), .SETTLE_CYCLES(1),
      .DWELL_CYCLES(1), .CNT_WIDTH(16)
   ) u_b (
      .clk(clk), .rst(rst), .start(start_b),
      .busy(busy_b), .done(done_b),
      .delay(delay_b), .delay_ld(ld_b),
      .err_clr(clr_b), .err_en(en_b),
      .err_cnt(cnt_b), .res_valid(valid_b),
      .res_ready(ready_b), .res_delay(rdel_b),
      .res_count(rcnt_b)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Error counters: clear wins, count while enabled, 1-cycle latency.
   always @(posedge clk) begin
      if (rst || clr_a) ecnt_a <= '0;
      else if (en_a)    ecnt_a <= ecnt_a + 16'd1;
      if (rst || clr_b) ecnt_b <= '0;
      else if (en_b)    ecnt_b <= ecnt_b + 16'd1;
   end

   assign cnt_a = force_ff ? 16'hFFFF : ecnt_a;
   assign cnt_b = ecnt_b;

   int res_n_a = 0, ld_n_a = 0, done_n_a = 0;
   int clr_n_a = 0, clr_bad = 0;
   logic [4:0]  res_tap_a [128];
   logic [15:0] res_val_a [128];
   logic [4:0]  ld_tap_a  [128];
   int          ld_cyc_a  [128];

   int res_n_b = 0, ld_n_b = 0, done_n_b = 0;
   logic [4:0]  res_tap_b [64];
   logic [15:0] res_val_b [64];

   // Event logs: handshakes, loads, clears, DONE pulses.
   always @(negedge clk) begin
      if (valid_a && ready_a && res_n_a < 128) begin
         res_tap_a[res_n_a] <= rdel_a;
         res_val_a[res_n_a] <= rcnt_a;
         res_n_a <= res_n_a + 1;
      end
      if (ld_a && ld_n_a < 128) begin
         ld_tap_a[ld_n_a] <= delay_a;
         ld_cyc_a[ld_n_a] <= cyc;
         ld_n_a <= ld_n_a + 1;
      end
      if (clr_a) clr_n_a <= clr_n_a + 1;
      if (clr_a != ld_a) clr_bad <= clr_bad + 1;
      if (done_a) done_n_a <= done_n_a + 1;
      if (valid_b && ready_b && res_n_b < 64) begin
         res_tap_b[res_n_b] <= rdel_b;
         res_val_b[res_n_b] <= rcnt_b;
         res_n_b <= res_n_b + 1;
      end
      if (ld_b) ld_n_b <= ld_n_b + 1;
      if (done_b) done_n_b <= done_n_b + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] req);
      n_cmp++;
      assert (obs === req) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, req);
      end
   endtask

   task automatic res_check_a(input string tag,
                              input int rb, input int db,
                              input int lb,
                              input logic [15:0] c0);
      chk({tag, " nres"}, 32'(res_n_a - rb), 32'd4);
      chk({tag, " ndone"}, 32'(done_n_a - db), 32'd1);
      chk({tag, " nld"}, 32'(ld_n_a - lb), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk({tag, " res tap"},
             32'(res_tap_a[rb+i]), 32'(i));
         chk({tag, " res cnt"},
             32'(res_val_a[rb+i]),
             (i == 0) ? 32'(c0) : 32'd8);
         chk({tag, " ld tap"},
             32'(ld_tap_a[lb+i]), 32'(i));
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, " busy"},  32'(busy_a),  32'd0);
      chk({tag, " done"},  32'(done_a),  32'd0);
      chk({tag, " delay"}, 32'(delay_a), 32'd0);
      chk({tag, " ld"},    32'(ld_a),    32'd0);
      chk({tag, " clr"},   32'(clr_a),   32'd0);
      chk({tag, " en"},    32'(en_a),    32'd0);
      chk({tag, " valid"}, 32'(valid_a), 32'd0);
      chk({tag, " rdel"},  32'(rdel_a),  32'd0);
      chk({tag, " rcnt"},  32'(rcnt_a),  32'd0);
   endtask

   initial begin
      int n, t0, rb, db, lb, cb;
      rst = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      ready_a = 1'b1;
      ready_b = 1'b1;
      force_ff = 1'b0;
      step();
      step();
      chk_reset_a("reset");
      chk("reset b delay", 32'(delay_b), 32'd0);
      chk("reset b busy", 32'(busy_b), 32'd0);
      rst = 1'b0;
      step();

      // Plain sweep, ready always high
      rb = res_n_a; db = done_n_a; lb = ld_n_a;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      t0 = cyc;
      chk("t1 busy", 32'(busy_a), 32'd1);
      chk("t1 ld", 32'(ld_a), 32'd1);
      chk("t1 clr", 32'(clr_a), 32'd1);
      chk("t1 delay", 32'(delay_a), 32'd0);
      step();
      chk("t1 ld 1cyc", 32'(ld_a), 32'd0);
      chk("t1 clr 1cyc", 32'(clr_a), 32'd0);
      n = 0;
      while (!done_a && n < 400) begin step(); n++; end
      chk("t1 done", 32'(done_a), 32'd1);
      chk("t1 busy@done", 32'(busy_a), 32'd1);
      chk("t1 length", 32'(cyc - t0), 32'd55);
      step();
      chk("t1 busy after", 32'(busy_a), 32'd0);
      chk("t1 done 1cyc", 32'(done_a), 32'd0);
      chk("t1 delay hold", 32'(delay_a), 32'd3);
      res_check_a("t1", rb, db, lb, 16'd8);
      chk("t1 first ld", 32'(ld_cyc_a[lb]), 32'(t0));
      for (int i = 0; i < 3; i++)
         chk("t1 period",
             32'(ld_cyc_a[lb+i+1] - ld_cyc_a[lb+i]),
             32'd14);

      // Back-pressure 20 cycles at tap 1
      rb = res_n_a; db = done_n_a; lb = ld_n_a;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      t0 = cyc;
      n = 0;
      while (!(valid_a && rdel_a == 5'd1) && n < 200) begin
         step(); n++;
      end
      chk("t2 report1", 32'(cyc - t0), 32'd26);
      ready_a = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("t2 stall valid", 32'(valid_a), 32'd1);
         chk("t2 stall rdel", 32'(rdel_a), 32'd1);
         chk("t2 stall rcnt", 32'(rcnt_a), 32'd8);
         chk("t2 stall ld", 32'(ld_a), 32'd0);
         step();
      end
      ready_a = 1'b1;
      chk("t2 valid held", 32'(valid_a), 32'd1);
      n = 0;
      while (!done_a && n < 400) begin step(); n++; end
      chk("t2 length", 32'(cyc - t0), 32'd75);
      step();
      res_check_a("t2", rb, db, lb, 16'd8);
      chk("t2 stalled period",
          32'(ld_cyc_a[lb+2] - ld_cyc_a[lb+1]), 32'd34);

      // START re-pulsed in MEASURE and REPORT, and in the DONE cycle
      rb = res_n_a; db = done_n_a; lb = ld_n_a;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      t0 = cyc;
      n = 0;
      while (!en_a && n < 100) begin step(); n++; end
      chk("t3 measure", 32'(en_a), 32'd1);
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      n = 0;
      while (!valid_a && n < 100) begin step(); n++; end
      chk("t3 report", 32'(valid_a), 32'd1);
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk("t3 no reload", 32'(ld_a), 32'd0);
      n = 0;
      while (!done_a && n < 400) begin step(); n++; end
      chk("t3 length", 32'(cyc - t0), 32'd55);
      start_a = 1'b1;
      step();
      chk("t3 start@done ignored", 32'(ld_a), 32'd0);
      chk("t3 idle busy", 32'(busy_a), 32'd0);
      res_check_a("t3", rb, db, lb, 16'd8);

      // Earliest restart, then reset during MEASURE at tap 2
      rb = res_n_a; db = done_n_a; lb = ld_n_a;
      step();
      start_a = 1'b0;
      chk("t4 restart ld", 32'(ld_a), 32'd1);
      chk("t4 restart busy", 32'(busy_a), 32'd1);
      chk("t4 restart delay", 32'(delay_a), 32'd0);
      n = 0;
      while (!(en_a && delay_a == 5'd2) && n < 200) begin
         step(); n++;
      end
      chk("t4 measure tap2", 32'(en_a), 32'd1);
      rst = 1'b1;
      step();
      chk_reset_a("t4 abort");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4 idle busy", 32'(busy_a), 32'd0);
      end
      chk("t4 no done", 32'(done_n_a - db), 32'd0);
      chk("t4 partial res", 32'(res_n_a - rb), 32'd2);
      rb = res_n_a; db = done_n_a; lb = ld_n_a;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      t0 = cyc;
      chk("t4 new ld", 32'(ld_a), 32'd1);
      chk("t4 new delay", 32'(delay_a), 32'd0);
      n = 0;
      while (!done_a && n < 400) begin step(); n++; end
      chk("t4 length", 32'(cyc - t0), 32'd55);
      step();
      res_check_a("t4", rb, db, lb, 16'd8);

      // Saturated count captured in CAPTURE
      rb = res_n_a; db = done_n_a; lb = ld_n_a;
      cb = clr_n_a;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      n = 0;
      while (!en_a && n < 100) begin step(); n++; end
      n = 0;
      while (en_a && n < 100) begin step(); n++; end
      chk("t6 capture", 32'(en_a), 32'd0);
      force_ff = 1'b1;
      step();
      force_ff = 1'b0;
      chk("t6 valid", 32'(valid_a), 32'd1);
      chk("t6 rcnt", 32'(rcnt_a), 32'hFFFF);
      chk("t6 rdel", 32'(rdel_a), 32'd0);
      n = 0;
      while (!done_a && n < 400) begin step(); n++; end
      step();
      res_check_a("t6", rb, db, lb, 16'hFFFF);
      chk("t6 nclr", 32'(clr_n_a - cb), 32'd4);
      chk("clr with ld", 32'(clr_bad), 32'd0);

      // Full 32-tap sweep, minimal settle/dwell
      rb = res_n_b; db = done_n_b; lb = ld_n_b;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      t0 = cyc;
      n = 0;
      while (!done_b && n < 600) begin step(); n++; end
      chk("t5 done", 32'(done_b), 32'd1);
      chk("t5 length", 32'(cyc - t0), 32'd191);
      step();
      chk("t5 nres", 32'(res_n_b - rb), 32'd32);
      chk("t5 ndone", 32'(done_n_b - db), 32'd1);
      chk("t5 nld", 32'(ld_n_b - lb), 32'd32);
      for (int i = 0; i < 32; i++) begin
         chk("t5 res tap", 32'(res_tap_b[rb+i]), 32'(i));
         chk("t5 res cnt", 32'(res_val_b[rb+i]), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         chk("t5 delay hold", 32'(delay_b), 32'd31);
         chk("t5 no wrap ld", 32'(ld_b), 32'd0);
         chk("t5 busy low", 32'(busy_b), 32'd0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
